// File: rtl/interface_alu_uart_tx_pkg.sv
// interface_alu_uart_tx_pkg: frame tags and FSM encoding shared by the ALU->UART TX stage.
package interface_alu_uart_tx_pkg;
  localparam logic [1:0] TX_TAG_RESULT = 2'b11;
  localparam logic [1:0] TX_TAG_FLAGS  = 2'b10;
  localparam logic [1:0] RX_TAG_OP1    = 2'b00;
  localparam logic [1:0] RX_TAG_OP2    = 2'b01;
  localparam logic [1:0] RX_TAG_OPCODE = 2'b10;
`ifdef TX_FLAGS_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, FLAGS} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
`endif
endpackage

// File: rtl/interface_alu_uart_tx_if.sv
// interface_alu_uart_tx_if: ALU result input and UART TX side of the result transmitter.
interface interface_alu_uart_tx_if #(parameter int NB_DATA = 8, parameter int NB_FULL_DATA = 10);
  logic [NB_DATA-1:0]      result;
  logic                    result_valid;
  logic [1:0]              flags;
  logic                    tx_busy;
  logic                    tx_start;
  logic [NB_FULL_DATA-1:0] tx_data;
  logic                    fifo_empty;
  logic                    overflow;
  modport master (output result, result_valid, flags, tx_busy, input tx_start, tx_data, fifo_empty, overflow);
  modport slave  (input result, result_valid, flags, tx_busy, output tx_start, tx_data, fifo_empty, overflow);
endinterface

// File: rtl/interface_alu_uart_tx_result_fifo.sv
// result_fifo: synchronous FIFO; a push on a full FIFO is accepted only alongside a pop.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/interface_alu_uart_tx.sv
// interface_alu_uart_tx: buffers ALU results and sends tagged frames to UART TX.
// Define TX_FLAGS_EN to follow each result frame with a {carry, zero} flags frame.
module interface_alu_uart_tx
  import interface_alu_uart_tx_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_FULL_DATA = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input logic i_clk,
  input logic i_reset,
  interface_alu_uart_tx_if.slave bus
);
`ifdef TX_FLAGS_EN
  localparam int W = NB_DATA + 2;
`else
  localparam int W = NB_DATA;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_next;
  logic [W-1:0] din, head;
  logic [AW:0] count;
  logic [NB_FULL_DATA-1:0] tx_data;
  logic empty, full, pop, tx_start, overflow;
`ifdef TX_FLAGS_EN
  logic [1:0] flags;
  assign din = {bus.flags, bus.result};
  always_ff @(posedge i_clk)
    if (state == LOAD) flags <= head[W-1 -: 2];
`else
  assign din = bus.result;
`endif
  assign pop = state == LOAD;
  result_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_reset), .push(bus.result_valid), .pop(pop), .din(din),
    .dout(head), .empty(empty), .full(full), .count(count)
  );
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = (count != '0 && !bus.tx_busy) ? LOAD : IDLE;
      LOAD:      state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: state_next = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
`ifdef TX_FLAGS_EN
      WAIT_DONE: state_next = bus.tx_busy ? WAIT_DONE : (tx_data[NB_FULL_DATA-1 -: 2] == TX_TAG_RESULT) ? FLAGS : IDLE;
      FLAGS:     state_next = START;
`else
      WAIT_DONE: state_next = bus.tx_busy ? WAIT_DONE : IDLE;
`endif
      default:   state_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= state_next == START;
      if (state == LOAD) tx_data <= {TX_TAG_RESULT, head[NB_DATA-1:0]};
`ifdef TX_FLAGS_EN
      if (state == FLAGS) tx_data <= {TX_TAG_FLAGS, {(NB_DATA-2){1'b0}}, flags};
`endif
      if (bus.result_valid && full && !pop) overflow <= 1'b1;
    end
  end
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = tx_data;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = overflow;
endmodule
